conv_pool_stream: RTL

//   Streaming 3x3/stride-3 max-pool stage directly downstream of Conv.
//   - Consumes Conv's 6x6 raster output stream (one 16-bit word per cycle after
//     a start pulse) without buffering the full map.
//   - Emits the 2x2 pooled result in raster order.
//   - Replaces the static nine-input MaxPool, which needed the whole conv map

---
 rtl/conv_pool_stream_if.sv | 30 +++
 rtl/conv_pool_stream.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/conv_pool_stream_if.sv
// conv_pool_stream_if: the Conv-side sample stream and the pooled result stream of conv_pool_stream.
// The producer/consumer side uses the master modport and the pooling stage uses the slave modport.
interface conv_pool_stream_if #(
    parameter int DW = 16
);
    logic          in_st;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          dout_vld;
    logic          out_st;
    logic          busy;

    modport master (
        output in_st,
        output din,
        input  dout,
        input  dout_vld,
        input  out_st,
        input  busy
    );

    modport slave (
        input  in_st,
        input  din,
        output dout,
        output dout_vld,
        output out_st,
        output busy
    );
endinterface

// File: rtl/conv_pool_stream.sv
// conv_pool_stream: streaming WINxWIN, stride-WIN max-pool over a raster conv map, one accumulator per output column.
// Define SIGNED_CMP_EN for two's-complement comparison; the default build compares unsigned.
module conv_pool_stream #(
    parameter int DW     = 16,
    parameter int IN_DIM = 6,
    parameter int WIN    = 3
) (
    input  logic              clk,
    input  logic              rst,
    conv_pool_stream_if.slave bus
);
    localparam int NX = IN_DIM / WIN;
    localparam int CW = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
    localparam int PW = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int XW = (NX > 1) ? $clog2(NX) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] row_q, row_d, col_q, col_d;
    logic [PW-1:0] rowPh_q, rowPh_d, colPh_q, colPh_d;
    logic [XW-1:0] wx_q, wx_d;
    logic [DW-1:0] acc_q [NX];
    logic [DW-1:0] acc_d [NX];
    logic [DW-1:0] dout_q, dout_d;
    logic          vld_q, vld_d;
    logic          ost_q, ost_d;

    logic          lastSample;
    logic          winStart;
    logic          winDone;
    logic          clear;
    logic [DW-1:0] winMax;

    function automatic logic [DW-1:0] maxOf(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef SIGNED_CMP_EN
        return ($signed(b) > $signed(a)) ? b : a;
`else
        return (b > a) ? b : a;
`endif
    endfunction

    // Phase counters track row%WIN, col%WIN and col/WIN so no divider is needed.
    assign lastSample = (row_q == CW'(IN_DIM - 1)) && (col_q == CW'(IN_DIM - 1));
    assign winStart   = (rowPh_q == '0) && (colPh_q == '0);
    assign winDone    = (rowPh_q == PW'(WIN - 1)) && (colPh_q == PW'(WIN - 1));
    assign winMax     = winStart ? bus.din : maxOf(acc_q[wx_q], bus.din);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        rowPh_d = rowPh_q;
        colPh_d = colPh_q;
        wx_d    = wx_q;
        acc_d   = acc_q;
        dout_d  = dout_q;
        vld_d   = 1'b0;
        ost_d   = 1'b0;
        clear   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_st) begin
                    state_d = RUN;
                    clear   = 1'b1;
                end
            end
            RUN: begin
                // A start pulse mid-frame drops the current sample and everything pending.
                if (bus.in_st && !lastSample) begin
                    clear = 1'b1;
                end else begin
                    acc_d[wx_q] = winMax;
                    if (winDone) begin
                        dout_d = winMax;
                        vld_d  = 1'b1;
                        ost_d  = lastSample;
                    end
                    if (lastSample) begin
                        clear   = 1'b1;
                        state_d = bus.in_st ? RUN : IDLE;
                    end else if (col_q == CW'(IN_DIM - 1)) begin
                        col_d   = '0;
                        colPh_d = '0;
                        wx_d    = '0;
                        row_d   = row_q + 1'b1;
                        rowPh_d = (rowPh_q == PW'(WIN - 1)) ? '0 : rowPh_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                        if (colPh_q == PW'(WIN - 1)) begin
                            colPh_d = '0;
                            wx_d    = wx_q + 1'b1;
                        end else begin
                            colPh_d = colPh_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (clear) begin
            row_d   = '0;
            col_d   = '0;
            rowPh_d = '0;
            colPh_d = '0;
            wx_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            rowPh_q <= '0;
            colPh_q <= '0;
            wx_q    <= '0;
            for (int i = 0; i < NX; i++) acc_q[i] <= '0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            ost_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            rowPh_q <= rowPh_d;
            colPh_q <= colPh_d;
            wx_q    <= wx_d;
            acc_q   <= acc_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            ost_q   <= ost_d;
        end
    end

    assign bus.dout     = dout_q;
    assign bus.dout_vld = vld_q;
    assign bus.out_st   = ost_q;
    assign bus.busy     = (state_q == RUN);
endmodule
